// File: rtl/pcie_tx_cmd_splitter.sv
// Splits DMA commands from the TX command FIFO into PCIe requests that respect the payload limit
// and the 4 KB boundary. Optional counters: define PCIE_TX_SPLIT_STATS_EN.
module pcie_tx_cmd_splitter #(
  parameter int unsigned P_CMD_WIDTH  = 46,
  parameter int unsigned P_LEN_WIDTH  = 13,
  parameter int unsigned P_ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              max_payload,
  input  logic [2:0]              max_rd_req,
  input  logic                    cmd_empty_n,
  input  logic [P_CMD_WIDTH-1:0]  cmd_rd_data,
  output logic                    cmd_rd_en,
  output logic                    tx_req_valid,
  input  logic                    tx_req_ack,
  output logic                    tx_req_is_write,
  output logic [P_ADDR_WIDTH-1:0] tx_req_addr,
  output logic [10:0]             tx_req_len_dw,
  output logic                    tx_req_last,
  output logic                    busy,
  output logic                    cmd_err
`ifdef PCIE_TX_SPLIT_STATS_EN
  ,
  output logic [31:0]             stat_cmd_cnt,
  output logic [31:0]             stat_req_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StFetch, StCalc, StIssue} state_e;

  state_e                  state_q, state_d;
  logic                    is_write_q, is_write_d;
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [P_LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [2:0]              code_q, code_d;
  logic                    req_write_q, req_write_d;
  logic [P_ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [10:0]             req_len_q, req_len_d;
  logic                    req_last_q, req_last_d;

  logic                    cmd_is_write;
  logic [P_LEN_WIDTH-1:0]  cmd_len;
  logic [P_ADDR_WIDTH-1:0] cmd_addr;
  logic [2:0]              code_c;
  logic [10:0]             lim, bnd, lim_bnd, chunk;

  assign cmd_is_write = cmd_rd_data[P_CMD_WIDTH-1];
  assign cmd_len      = cmd_rd_data[P_ADDR_WIDTH +: P_LEN_WIDTH];
  assign cmd_addr     = cmd_rd_data[P_ADDR_WIDTH-1:0];

  // All three limits are at most 1024 DW, so the chunk fits the 11-bit request length.
  assign code_c  = (code_q > 3'd5) ? 3'd5 : code_q;
  assign lim     = 11'd32 << code_c;
  assign bnd     = 11'd1024 - {1'b0, addr_q[9:0]};
  assign lim_bnd = (lim < bnd) ? lim : bnd;
  assign chunk   = (rem_q < P_LEN_WIDTH'(lim_bnd)) ? rem_q[10:0] : lim_bnd;

  assign cmd_rd_en       = (state_q == StFetch) && cmd_empty_n;
  assign cmd_err         = cmd_rd_en && (cmd_len == '0);
  assign tx_req_valid    = (state_q == StIssue);
  assign busy            = (state_q != StIdle);
  assign tx_req_is_write = req_write_q;
  assign tx_req_addr     = req_addr_q;
  assign tx_req_len_dw   = req_len_q;
  assign tx_req_last     = req_last_q;

  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    code_d      = code_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_len_d   = req_len_q;
    req_last_d  = req_last_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_empty_n) state_d = StFetch;
      end
      StFetch: begin
        if (cmd_empty_n) begin
          is_write_d = cmd_is_write;
          addr_d     = cmd_addr;
          rem_d      = cmd_len;
          code_d     = cmd_is_write ? max_payload : max_rd_req;
          state_d    = (cmd_len == '0) ? StIdle : StCalc;
        end else begin
          state_d = StIdle;
        end
      end
      StCalc: begin
        req_write_d = is_write_q;
        req_addr_d  = addr_q;
        req_len_d   = chunk;
        req_last_d  = (P_LEN_WIDTH'(chunk) == rem_q);
        state_d     = StIssue;
      end
      StIssue: begin
        if (tx_req_ack) begin
          addr_d  = addr_q + P_ADDR_WIDTH'(req_len_q);
          rem_d   = rem_q - P_LEN_WIDTH'(req_len_q);
          state_d = req_last_q ? StIdle : StCalc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      is_write_q  <= 1'b0;
      addr_q      <= '0;
      rem_q       <= '0;
      code_q      <= '0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_len_q   <= '0;
      req_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      code_q      <= code_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_len_q   <= req_len_d;
      req_last_q  <= req_last_d;
    end
  end

`ifdef PCIE_TX_SPLIT_STATS_EN
  logic [31:0] stat_cmd_q, stat_req_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cmd_q <= '0;
      stat_req_q <= '0;
    end else begin
      if (cmd_rd_en && !cmd_err) stat_cmd_q <= stat_cmd_q + 32'd1;
      if (tx_req_valid && tx_req_ack) stat_req_q <= stat_req_q + 32'd1;
    end
  end

  assign stat_cmd_cnt = stat_cmd_q;
  assign stat_req_cnt = stat_req_q;
`endif

endmodule

// File: tb/tb_pcie_tx_cmd_splitter.sv
// Scoreboard bench for pcie_tx_cmd_splitter: a FIFO model feeds directed commands, a monitor
// pops hand-computed expected requests on every accepted handshake.
module tb_pcie_tx_cmd_splitter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  max_payload, max_rd_req;
  logic        cmd_empty_n;
  logic [45:0] cmd_rd_data;
  logic        cmd_rd_en, tx_req_valid, tx_req_ack, tx_req_is_write;
  logic [31:0] tx_req_addr;
  logic [10:0] tx_req_len_dw;
  logic        tx_req_last, busy, cmd_err;
`ifdef PCIE_TX_SPLIT_STATS_EN
  logic [31:0] stat_cmd_cnt, stat_req_cnt;
`endif

  always #5 clk = ~clk;

  pcie_tx_cmd_splitter dut (
    .clk             (clk),
    .rst             (rst),
    .max_payload     (max_payload),
    .max_rd_req      (max_rd_req),
    .cmd_empty_n     (cmd_empty_n),
    .cmd_rd_data     (cmd_rd_data),
    .cmd_rd_en       (cmd_rd_en),
    .tx_req_valid    (tx_req_valid),
    .tx_req_ack      (tx_req_ack),
    .tx_req_is_write (tx_req_is_write),
    .tx_req_addr     (tx_req_addr),
    .tx_req_len_dw   (tx_req_len_dw),
    .tx_req_last     (tx_req_last),
    .busy            (busy),
    .cmd_err         (cmd_err)
`ifdef PCIE_TX_SPLIT_STATS_EN
    ,
    .stat_cmd_cnt    (stat_cmd_cnt),
    .stat_req_cnt    (stat_req_cnt)
`endif
  );

  typedef struct packed {
    logic        w;
    logic [31:0] addr;
    logic [10:0] len;
    logic        last;
  } req_t;

  req_t        exp_q[$];
  logic [45:0] fifo_mem [0:63];
  int          wr_ptr, rd_ptr;
  int          checks, errors;
  int          pops, err_cnt, valid_cnt;
  bit          ack_en, gap_chk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_cmd(input logic w, input logic [12:0] len, input logic [31:0] addr);
    fifo_mem[wr_ptr % 64] = {w, len, addr};
    wr_ptr++;
  endtask

  task automatic push_exp(input logic w, input logic [31:0] addr, input logic [10:0] len,
                          input logic last);
    req_t e;
    e = '{w: w, addr: addr, len: len, last: last};
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rd_ptr == wr_ptr && !busy && exp_q.size() == 0) && n < budget);
    check(name, (rd_ptr == wr_ptr && !busy && exp_q.size() == 0), 1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_req_valid && n < budget);
    check(name, tx_req_valid, 1);
  endtask

  // FIFO model, ack driver and response monitor share one process so every counter has one writer.
  task automatic bench_loop();
    req_t cur, snap, e;
    bit   held = 0, rd_seen, prev_nonlast = 0;
    int   cyc = 0, last_acc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      rd_seen = cmd_rd_en;
      if (rst) prev_nonlast = 0;
      if (cmd_rd_en) begin
        pops++;
        check("rd_en_while_empty", cmd_empty_n, 1);
      end
      if (cmd_err) err_cnt++;
      if (tx_req_valid) begin
        valid_cnt++;
        cur = '{w: tx_req_is_write, addr: tx_req_addr, len: tx_req_len_dw, last: tx_req_last};
        if (held) check("hold_stable", cur, snap);
        held = !tx_req_ack;
        snap = cur;
        if (tx_req_ack) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req actual=%0h required=none", cur);
          end else begin
            e = exp_q.pop_front();
            check("req", cur, e);
          end
          if (gap_chk && prev_nonlast) check("req_gap", cyc - last_acc, 2);
          prev_nonlast = !tx_req_last;
          last_acc = cyc;
        end
      end else begin
        held = 0;
      end
      @(posedge clk);
      #1;
      if (rd_seen) rd_ptr++;
      cmd_empty_n = (rd_ptr != wr_ptr);
      cmd_rd_data = fifo_mem[rd_ptr % 64];
      tx_req_ack  = ack_en;
    end
  endtask

  task automatic run_main();
    int e0, p0, v0;
    rst = 1'b1; ack_en = 1; gap_chk = 1; max_payload = 3'd0; max_rd_req = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_valid", tx_req_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en", cmd_rd_en, 0);
    check("rst_err", cmd_err, 0);
    check("rst_last", tx_req_last, 0);
    check("rst_outs", {tx_req_is_write, tx_req_addr, tx_req_len_dw}, 0);
    rst = 1'b0;

    // Write limited by 128 B payload
    push_cmd(1'b1, 13'd64, 32'h100);
    push_exp(1'b1, 32'h100, 11'd32, 1'b0);
    push_exp(1'b1, 32'h120, 11'd32, 1'b1);
    wait_idle("t1_done", 50);

    // Read split only at the 4 KB boundary
    max_rd_req = 3'd5;
    push_cmd(1'b0, 13'd300, 32'h3F0);
    push_exp(1'b0, 32'h3F0, 11'd16, 1'b0);
    push_exp(1'b0, 32'h400, 11'd284, 1'b1);
    wait_idle("t2_done", 50);

    // Maximum length read
    push_cmd(1'b0, 13'd8191, 32'h0);
    for (int i = 0; i < 7; i++) push_exp(1'b0, 32'(i * 1024), 11'd1024, 1'b0);
    push_exp(1'b0, 32'h1C00, 11'd1023, 1'b1);
    wait_idle("t3_done", 100);

    // Address wrap at 2^32 DW
    max_payload = 3'd5;
    push_cmd(1'b1, 13'd40, 32'hFFFF_FFF0);
    push_exp(1'b1, 32'hFFFF_FFF0, 11'd16, 1'b0);
    push_exp(1'b1, 32'h0, 11'd24, 1'b1);
    wait_idle("t7_done", 50);

    // Zero-length command is dropped
    e0 = err_cnt; p0 = pops; v0 = valid_cnt;
    push_cmd(1'b1, 13'd0, 32'h777);
    wait_idle("t4_done", 20);
    check("t4_err_pulses", err_cnt - e0, 1);
    check("t4_pops", pops - p0, 1);
    check("t4_no_valid", valid_cnt - v0, 0);

    // Back-pressure with a mid-command limit change
    gap_chk = 0; ack_en = 0; max_payload = 3'd0;
    push_cmd(1'b1, 13'd96, 32'h0);
    push_exp(1'b1, 32'h00, 11'd32, 1'b0);
    push_exp(1'b1, 32'h20, 11'd32, 1'b0);
    push_exp(1'b1, 32'h40, 11'd32, 1'b1);
    wait_valid("t5_valid", 20);
    repeat (3) @(negedge clk);
    max_payload = 3'd5;
    repeat (7) @(negedge clk);
    ack_en = 1;
    wait_idle("t5_done", 50);
    gap_chk = 1;

    // Reset during ISSUE discards the command
    ack_en = 0; max_rd_req = 3'd0;
    push_cmd(1'b0, 13'd64, 32'h200);
    wait_valid("t6_valid", 20);
    rst = 1'b1;
    @(negedge clk);
    check("t6_valid_after_rst", tx_req_valid, 0);
    check("t6_busy_after_rst", busy, 0);
    rst = 1'b0; ack_en = 1;
    push_cmd(1'b0, 13'd32, 32'h500);
    push_exp(1'b0, 32'h500, 11'd32, 1'b1);
    wait_idle("t6_done", 30);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  initial begin
    cmd_empty_n = 1'b0;
    cmd_rd_data = '0;
    tx_req_ack  = 1'b0;
    wr_ptr = 0; rd_ptr = 0;
    checks = 0; errors = 0;
    pops = 0; err_cnt = 0; valid_cnt = 0;
    fork
      bench_loop();
    join_none
    run_main();
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
